// File: rtl/imem_fetch_ctrl.sv
// rtl/imem_fetch_ctrl.sv - instruction fetch sequencer with fetch queue, redirect and halt detect
// Optional debug read port on imem enabled by defining IMEM_DBG_PORT_EN.
module imem_fetch_ctrl #(
    parameter logic [7:0] RESET_PC = 8'h00,
    parameter int         FQ_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic [5:0]  imem_addr,
    input  logic [31:0] imem_instr,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_instr,
    output logic [7:0]  if_pc,
    input  logic        redir_valid,
    input  logic [7:0]  redir_pc,
    output logic        halted
`ifdef IMEM_DBG_PORT_EN
    ,
    input  logic        dbg_req,
    input  logic [5:0]  dbg_addr,
    output logic        dbg_gnt,
    output logic [31:0] dbg_rdata
`endif
);

    localparam int PW = $clog2(FQ_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FQ_DEPTH);

    typedef enum logic {
        FETCH,
        HALTED
    } state_t;

    state_t         state;
    logic [7:0]     pc;
    logic [7:0]     q_pc    [FQ_DEPTH];
    logic [31:0]    q_instr [FQ_DEPTH];
    logic [PW-1:0]  rd_ptr;
    logic [PW-1:0]  wr_ptr;
    logic [CW-1:0]  count;
    logic           halted_q;
    logic           dbg_gnt_int;
    logic           pop;
    logic           push;
    logic           halt_jump;
    logic           unused_redir_lsbs;

    assign unused_redir_lsbs = ^redir_pc[1:0];

`ifdef IMEM_DBG_PORT_EN
    assign dbg_gnt_int = dbg_req & ~redir_valid;
    assign dbg_gnt     = dbg_gnt_int;
    assign imem_addr   = dbg_gnt_int ? dbg_addr : pc[7:2];

    // Debug read data is captured only on a grant edge and held otherwise.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dbg_rdata <= 32'h0;
        end else if (dbg_gnt_int) begin
            dbg_rdata <= imem_instr;
        end
    end
`else
    assign dbg_gnt_int = 1'b0;
    assign imem_addr   = pc[7:2];
`endif

    always_comb begin
        pop       = if_valid & if_ready;
        push      = (state == FETCH) & ~redir_valid & ((count < DEPTH_C) | pop) & ~dbg_gnt_int;
        halt_jump = (imem_instr[31:26] == 6'b000010) && ({imem_instr[5:0], 2'b00} == pc);
    end

    assign if_valid = (count != '0);
    assign if_instr = if_valid ? q_instr[rd_ptr] : 32'h0;
    assign if_pc    = if_valid ? q_pc[rd_ptr]    : 8'h0;
    assign halted   = halted_q;

    // Entry storage needs no reset: count gates visibility of every slot.
    always_ff @(posedge clk) begin
        if (push) begin
            q_pc[wr_ptr]    <= pc;
            q_instr[wr_ptr] <= imem_instr;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= FETCH;
            pc       <= RESET_PC;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            halted_q <= 1'b0;
        end else if (redir_valid) begin
            // Flush discards every queued entry, including one being popped now.
            state    <= FETCH;
            pc       <= {redir_pc[7:2], 2'b00};
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            halted_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
                pc     <= pc + 8'd4;
                if (halt_jump) begin
                    state    <= HALTED;
                    halted_q <= 1'b1;
                end
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule
